ham_decoder: RTL and testbench
==============================

Name: ham_decoder

Overview:
- Pipelined Hamming(7,4) single-error-correcting decoder; the receive-side counterpart of ham_encoder.
- Accepts 7-bit codewords over a valid/ready stream, computes the syndrome, corrects any single-bit error and emits the 4-bit data word with status.
- Sits on the receive path downstream of the channel or storage.

Parameters:
CNT_W, 16, width of the corrected-error counter (used only with HAM_ERR_CNT_EN).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  in_code is valid this cycle
in_ready  output  1  decoder accepts in_code this cycle
in_code  input  7  received codeword; bit i = Hamming position i+1 (bit0=p1, bit1=p2, bit2=d0, bit3=p4, bit4=d1, bit5=d2, bit6=d3)
out_valid  output  1  out_* fields hold a decoded word
out_ready  input  1  downstream accepts the decoded word
out_data  output  4  corrected data {c6,c5,c4,c2}
out_syndrome  output  3  {s4,s2,s1}; 0 = no error, else the 1-based position of the flipped bit
out_err  output  1  1 = a single-bit error was corrected (out_syndrome != 0)
err_count  output  CNT_W  corrected-error count (present only with HAM_ERR_CNT_EN)
err_clr  input  1  synchronous clear of err_count (present only with HAM_ERR_CNT_EN)

Behaviour:
- Reset (rst_n low, asynchronous): both stage valid flags=0, out_valid=0, out_data=0, out_syndrome=0, out_err=0, err_count=0.
- in_ready is combinational: in_ready = !s1_valid || s1_adv.
- Stage 1 (S1): on in_valid && in_ready, register in_code and compute the syndrome:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - Set s1_valid=1.
- Stage 2 (S2 / output regs):
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - On s1_adv: corrected = code ^ (syn!=0 ? (1<<(syn-1)) : 0); out_data = {corrected[6], corrected[5], corrected[4], corrected[2]}; out_syndrome = syn; out_err = (syn!=0); out_valid=1.
  - If out_valid && out_ready && !s1_valid, out_valid clears to 0.
- Latency: 2 clk from accepted input to out_valid with no backpressure. Throughput: 1 word/clk.
- Backpressure:
  - With out_ready low, out_* hold stable and S1 holds its word, so in_ready drops once both stages are full.
  - No word is dropped or duplicated.
  - Order is preserved.
- Simultaneous S1 load and S1 transfer in the same cycle is legal; S1 holds the new word.
- Double-bit errors are not detected: they alias to a nonzero syndrome and miscorrect. This is documented, not flagged.
- Reset mid-stream discards all in-flight words. There are no outputs on the first cycle after reset deassertion.
- out_data/out_syndrome are don't-care while out_valid=0, but remain registered (no combinational path from in_code).

Optional Feature:
HAM_ERR_CNT_EN
- Defined:
  - Adds err_count/err_clr.
  - err_count increments by 1 on each output handshake (out_valid && out_ready) with out_err=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - err_clr zeroes the counter next clk and wins over a simultaneous increment.
- Undefined: the ports and counter logic are absent; decode behaviour is identical.

Test Plan:
- Clean codeword: in_code=7'b1010101, out_ready=1 -> 2 clk later out_data=4'b1011, out_syndrome=0, out_err=0.
- Single error (flip bit4): in_code=7'b1000101 -> out_data=4'b1011, out_syndrome=3'd5, out_err=1. Sweep all 7 single flips of 1010101 -> syndrome 1..7, data always 1011.
- Streaming: in_code 0000000, 1111111, 1010101 on back-to-back cycles -> out_data 0000, 1111, 1011 on 3 consecutive cycles starting 2 clk after the first input.
- Backpressure: out_ready=0 for 5 clk during a 4-word burst -> in_ready=0 after 2 words accepted, out_* stable; release -> all 4 words emitted in order.
- Reset mid-operation: assert rst_n=0 with both stages full -> out_valid=0 immediately (asynchronous), no stale word emitted after release.
- HAM_ERR_CNT_EN with CNT_W=2: send 5 single-error words -> err_count=3 (saturated); pulse err_clr together with an error handshake -> err_count=0.

Source files
------------

// File: rtl/ham_decoder.sv
// ham_decoder: two-stage Hamming(7,4) single-error-correcting decoder.
// Stage 1 registers the received codeword and its syndrome. Stage 2 holds the
// corrected data word and status in the output registers.
// Codeword bit i is Hamming position i+1 (bit0=p1, bit1=p2, bit2=d0, bit3=p4,
// bit4=d1, bit5=d2, bit6=d3).
// Double-bit errors are not detected: they alias to a single-bit syndrome and
// are miscorrected.
// Optional build macro HAM_ERR_CNT_EN adds a saturating corrected-error
// counter (err_count, CNT_W bits) with a synchronous clear input (err_clr).
module ham_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_err
`ifdef HAM_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("ham_decoder: CNT_W must be at least 1");
  end

  logic       s1_valid;
  logic [6:0] s1_code;
  logic [2:0] s1_syn;
  logic       s2_adv;
  logic       s1_adv;
  logic [6:0] fix_mask;
  logic [6:0] corrected;

  // The output stage can take a new word when it is empty or is being drained
  // this cycle. Stage 1 can take a new word when it is empty or is moving on.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s1_adv;

  // Stage 1: capture the codeword and its syndrome {s4,s2,s1} on an accept.
  // A load in the same cycle as a transfer out leaves the new word held here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_code  <= in_code;
      s1_syn   <= {in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6],
                   in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6],
                   in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6]};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // A nonzero syndrome names the 1-based position of the bit to flip back.
  always_comb begin
    fix_mask = '0;
    if (s1_syn != 3'd0) begin
      fix_mask = 7'd1 << (s1_syn - 3'd1);
    end
    corrected = s1_code ^ fix_mask;
  end

  // Stage 2: load the corrected word and status when stage 1 advances, and
  // drop out_valid once the held word is taken with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
    end else if (s1_adv) begin
      out_valid    <= 1'b1;
      out_data     <= {corrected[6], corrected[5], corrected[4], corrected[2]};
      out_syndrome <= s1_syn;
      out_err      <= (s1_syn != 3'd0);
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef HAM_ERR_CNT_EN
  // Count corrected words as they leave; saturate at all-ones, and let a
  // clear take priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ham_decoder.sv
// tb_ham_decoder: directed bench for ham_decoder with a scoreboard model.
// The model decodes by XOR-ing the positions of all set bits (the syndrome of
// a Hamming code) and tracks pipeline occupancy with a queue of pending words.
// Build with HAM_ERR_CNT_EN to also exercise the error counter (CNT_W=2).
module tb_ham_decoder;

`ifdef HAM_ERR_CNT_EN
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`else
  localparam int CNT_W = 16;
`endif

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_err;
`ifdef HAM_ERR_CNT_EN
  logic [CNT_W-1:0] err_count;
  logic             err_clr;
  int               exp_cnt;
`endif

  int   checks;
  int   errors;
  int   acc_count;
  bit   stop;
  exp_t q[$];
  bit         hold_valid;
  logic [3:0] hold_data;
  logic [2:0] hold_syn;
  logic       hold_err;

  ham_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_code(in_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_syndrome(out_syndrome),
    .out_err(out_err)
`ifdef HAM_ERR_CNT_EN
    ,
    .err_count(err_count),
    .err_clr(err_clr)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Syndrome = XOR of the 1-based positions of all set bits; flip that bit.
  function automatic exp_t model_decode(input logic [6:0] code);
    exp_t r;
    int s;
    logic [6:0] f;
    s = 0;
    for (int i = 0; i < 7; i++) if (code[i]) s = s ^ (i + 1);
    f = code;
    if (s != 0) f[s-1] = ~f[s-1];
    r.data = {f[6], f[5], f[4], f[2]};
    r.syn  = 3'(s);
    r.err  = (s != 0);
    return r;
  endfunction

  // Place data at positions 3,5,6,7 then set parity bits to cancel the syndrome.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    int s;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    s = 0;
    for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
    for (int b = 0; b < 3; b++) if (s[b]) c[(1 << b) - 1] = 1'b1;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one codeword from posedge+1 until it is accepted (bounded).
  task automatic send(input logic [6:0] code);
    bit ok;
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_code  = code;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        done = 1;
        acc_count++;
      end
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  // Wait until the scoreboard holds no pending words (bounded).
  task automatic drain();
    bit done;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Compare process: at every negedge check handshake readiness, output word,
  // hold stability and the counter against the model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_valid = 0;
`ifdef HAM_ERR_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
      check("in_ready", in_ready, (q.size() < 2) ? 1'b1 : out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          check("out_data", out_data, q[0].data);
          check("out_syndrome", out_syndrome, q[0].syn);
          check("out_err", out_err, q[0].err);
        end
      end
      if (hold_valid) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_data, out_syndrome, out_err}, {hold_data, hold_syn, hold_err});
      end
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
      hold_syn   = out_syndrome;
      hold_err   = out_err;
`ifdef HAM_ERR_CNT_EN
      check("err_count", err_count, exp_cnt);
      if (err_clr) exp_cnt = 0;
      else if (out_valid && out_ready && q.size() > 0 && q[0].err && exp_cnt < CNT_MAX) exp_cnt++;
`endif
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model_decode(in_code));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    exp_t m;
    checks = 0;
    errors = 0;
    acc_count = 0;
    stop = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_code = '0;
    out_ready = 1'b1;
`ifdef HAM_ERR_CNT_EN
    err_clr = 1'b0;
    exp_cnt = 0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_syndrome", out_syndrome, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef HAM_ERR_CNT_EN
    check("rst_err_count", err_count, 0);
`endif

    // Hand-computed pins on the model.
    m = model_decode(7'b1010101);
    check("pin_clean", {m.data, m.syn, m.err}, {4'b1011, 3'd0, 1'b0});
    m = model_decode(7'b1000101);
    check("pin_flip5", {m.data, m.syn, m.err}, {4'b1011, 3'd5, 1'b1});
    m = model_decode(7'b1010110);
    check("pin_double", {m.data, m.syn, m.err}, {4'b1010, 3'd3, 1'b1});
    check("pin_encode", encode(4'b1011), 7'b1010101);

    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Single clean word with explicit two-clock latency.
    send(7'b1010101);
    @(negedge clk);
    check("lat_s1_only", out_valid, 0);
    @(negedge clk);
    check("lat_out_valid", out_valid, 1);
    check("lat_out_data", out_data, 4'b1011);
    check("lat_out_syn", out_syndrome, 0);
    check("lat_out_err", out_err, 0);
    drain();

    // All seven single-bit flips of 1010101 plus one double flip.
    for (int i = 0; i < 7; i++) send(7'b1010101 ^ (7'd1 << i));
    send(7'b1010110);
    drain();

    // Back-to-back stream with cycle-exact output timing.
    in_valid = 1'b1;
    in_code = 7'b0000000;
    @(negedge clk);
    check("stream_c0_valid", out_valid, 0);
    @(posedge clk); #1;
    in_code = 7'b1111111;
    @(negedge clk);
    check("stream_c1_valid", out_valid, 0);
    @(posedge clk); #1;
    in_code = 7'b1010101;
    @(negedge clk);
    check("stream_w0_valid", out_valid, 1);
    check("stream_w0_data", out_data, 4'b0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_w1_valid", out_valid, 1);
    check("stream_w1_data", out_data, 4'b1111);
    @(negedge clk);
    check("stream_w2_valid", out_valid, 1);
    check("stream_w2_data", out_data, 4'b1011);
    @(negedge clk);
    check("stream_end_valid", out_valid, 0);
    @(posedge clk); #1;

    // Backpressure: out_ready low for 5 clocks during a 4-word burst.
    acc_count = 0;
    out_ready = 1'b0;
    fork
      begin
        send(7'b0000000);
        send(7'b1111111);
        send(7'b1000101);
        send(7'b0110011);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_accepted", acc_count, 2);
        check("bp_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_total", acc_count, 4);

    // All 16 data words under random backpressure.
    stop = 0;
    fork
      begin
        for (int d = 0; d < 16; d++) send(encode(4'(d)));
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          if (!stop) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(7'b1010101);
    send(7'b0000001);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_word", out_valid, 0);
    end
    @(posedge clk); #1;

`ifdef HAM_ERR_CNT_EN
    // Counter: clear, saturate after five errors, clear beats an increment.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("cnt_cleared", err_count, 0);
    for (int i = 0; i < 5; i++) send(7'b1010101 ^ (7'd1 << i));
    drain();
    @(negedge clk);
    check("cnt_saturated", err_count, 3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(7'b1000101);
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      if (!seen) check("cnt_wait_timeout", 0, 1);
    end
    @(posedge clk); #1;
    err_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("cnt_clr_wins", err_count, 0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
